lif_tdm_scheduler: RTL and testbench
====================================

// Module: lif_tdm_scheduler
// PURPOSE
//  Time-multiplexes one leaky integrate-and-fire update datapath across
//  NUM_NEURONS virtual neurons. Membrane states live in a local register array.
//  Each timestep the block fetches one input current per neuron, updates that
//  neuron's state and emits spike events over a valid/ready stream.
//  Sits between the input-current source (e.g. a synapse accumulator) and the
//  spike router.
// PARAMETERS
//  NUM_NEURONS   8    number of virtual neurons (>=2); IDXW = $clog2(NUM_NEURONS)
//  THR_DEFAULT   230  threshold loaded at reset
//  REFRAC_STEPS  2    refractory length in timesteps (used only with LIF_REFRACTORY_EN)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     reset, asynchronous, active-high
//  step_start   in   1     start one timestep; sampled only in IDLE
//  busy         out  1     high from the cycle after step_start until DONE
//  step_done    out  1     one-cycle pulse when all neurons are updated
//  cur_req      out  1     current request for neuron cur_idx
//  cur_idx      out  IDXW  neuron whose current is requested
//  cur_valid    in   1     cur_data valid; accepted in any cycle with cur_req=1
//  cur_data     in   8     unsigned input current
//  spk_valid    out  1     spike event valid
//  spk_idx      out  IDXW  spiking neuron index; stable while spk_valid=1
//  spk_ready    in   1     spike consumer ready
//  cfg_we       in   1     threshold write strobe
//  cfg_thr      in   8     new threshold value
//  spk_count    out  8     spikes emitted this timestep; saturates at 255
// BEHAVIOUR
//  Reset: U[*]=0, thr=THR_DEFAULT, FSM=IDLE, idx=0, spk_count=0.
//   All outputs low/zero. Reset takes effect mid-step and abandons the step.
//  FSM states IDLE, FETCH, EMIT, DONE:
//   IDLE : step_start=1 -> FETCH, idx=0, spk_count=0.
//   FETCH: cur_req=1, cur_idx=idx. Waits while cur_valid=0.
//          On cur_valid=1: write U[idx] in the same cycle.
//          If spike -> EMIT; else advance.
//   EMIT : spk_valid=1, spk_idx=idx. Held until spk_ready=1; then spk_count++
//          and advance.
//   advance: idx==NUM_NEURONS-1 -> DONE, else idx+1 -> FETCH.
//   DONE : step_done=1 for one cycle, then IDLE.
//  Throughput: 1 cycle/neuron with no spikes and cur_valid held high.
//   Each spike adds >=1 cycle.
//  Update for neuron i (8-bit unsigned, U = stored state):
//   spike = (U >= thr), compared against the state before this update.
//   If spike: U' = 0 and the input current is discarded.
//   Else: U' = min(255, cur_data + (U>>1)+(U>>2)+(U>>3)).
//     The sum is computed 9 bits wide, then saturated.
//  cfg_we: updates thr when the FSM is IDLE; ignored in any other state.
//  step_start outside IDLE is ignored (no queuing).
//  spk_ready is don't-care outside EMIT.
//  cur_valid is don't-care outside FETCH.
// CONFIGURATION
//  LIF_REFRACTORY_EN defined: per-neuron counter R[i] of width clog2(REFRAC_STEPS+1).
//   A spike sets R[i]=REFRAC_STEPS.
//   In a later step with R[i]>0: the current is still fetched and discarded,
//     U'=0, there is no spike, and R[i] decrements.
//   R[*] is cleared at reset.
//  LIF_REFRACTORY_EN undefined: no counters; the neuron integrates on the next step.
// STRUCTURE
//  Package lif_pkg holds:
//   - STATE_W=8
//   - FSM enum typedef lif_sched_state_t
//   - function lif_decay(U) = (U>>1)+(U>>2)+(U>>3)
//   - saturating-add function
//  Sub-module lif_update_unit: combinational (U, I, thr[, refractory]) -> (U', spike).
//   It is the shared datapath instantiated once.
//  The scheduler owns the FSM, the state array, idx, thr and spk_count.
// TESTING
//  1. thr=230, all U=0, step with cur_data=10 for all neurons, spk_ready=1:
//     all U=10, no spk_valid, step_done exactly NUM_NEURONS+1 cycles after FETCH entry.
//  2. U[3]=200, cur_data=10: U[3]=185.
//     U[3]=200, cur_data=100: U[3]=255 (saturation).
//  3. U[5]=255, thr=230: spk_valid with spk_idx=5.
//     Hold spk_ready=0 for 4 cycles: spk_idx stable, no progress.
//     Then U[5]=0, spk_count=1.
//  4. cur_valid low 3 cycles at idx=2: cur_req/cur_idx held, no state change.
//     cfg_we during busy leaves thr unchanged.
//  5. rst_n=1 mid-EMIT: outputs low in the same cycle, U[*]=0, thr=230, FSM IDLE.
//     step_start after release runs a clean step.
//  6. LIF_REFRACTORY_EN defined: after a spike on neuron 0, the next 2 steps with
//     cur_data=255 keep U[0]=0 with no spike; the third step gives U[0]=255.

Source files
------------

// File: rtl/lif_pkg.sv
// lif_pkg: shared widths, scheduler state encoding and LIF arithmetic helpers
package lif_pkg;
   localparam int STATE_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} lif_sched_state_t;

   function automatic logic [STATE_W-1:0] lif_decay(input logic [STATE_W-1:0] u);
      return (u >> 1) + (u >> 2) + (u >> 3);
   endfunction

   function automatic logic [STATE_W-1:0] lif_sat_add(input logic [STATE_W-1:0] a,
                                                      input logic [STATE_W-1:0] b);
      logic [STATE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STATE_W] ? {STATE_W{1'b1}} : s[STATE_W-1:0];
   endfunction
endpackage

// File: rtl/lif_update_unit.sv
// lif_update_unit: combinational leaky integrate-and-fire step for one neuron (LIF_REFRACTORY_EN adds the refractory input)
module lif_update_unit
   import lif_pkg::*;
(
`ifdef LIF_REFRACTORY_EN
   input  logic               refrac,
`endif
   input  logic [STATE_W-1:0] u,
   input  logic [STATE_W-1:0] cur,
   input  logic [STATE_W-1:0] thr,
   output logic [STATE_W-1:0] u_next,
   output logic               spike
);
`ifdef LIF_REFRACTORY_EN
   logic hold;
   assign hold = refrac;
`else
   logic hold;
   assign hold = 1'b0;
`endif

   // fire on the pre-update state; a firing or refractory neuron drops its current and resets
   always_comb begin
      spike  = (u >= thr) && !hold;
      u_next = (spike || hold) ? '0 : lif_sat_add(cur, lif_decay(u));
   end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: time-multiplexed LIF neuron array with spike stream (optional LIF_REFRACTORY_EN)
module lif_tdm_scheduler
   import lif_pkg::*;
#(
   parameter int NUM_NEURONS  = 8,
   parameter int THR_DEFAULT  = 230,
   parameter int REFRAC_STEPS = 2,
   localparam int IDXW        = $clog2(NUM_NEURONS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step_start,
   output logic               busy,
   output logic               step_done,
   output logic               cur_req,
   output logic [IDXW-1:0]    cur_idx,
   input  logic               cur_valid,
   input  logic [STATE_W-1:0] cur_data,
   output logic               spk_valid,
   output logic [IDXW-1:0]    spk_idx,
   input  logic               spk_ready,
   input  logic               cfg_we,
   input  logic [STATE_W-1:0] cfg_thr,
   output logic [7:0]         spk_count
);
   lif_sched_state_t   state;
   logic [IDXW-1:0]    idx;
   logic [STATE_W-1:0] thr;
   logic [STATE_W-1:0] u_mem [NUM_NEURONS];
   logic [STATE_W-1:0] u_next;
   logic               spike;
   logic               last;

   assign last    = idx == IDXW'(NUM_NEURONS - 1);
   assign cur_idx = idx;
   assign spk_idx = idx;

`ifdef LIF_REFRACTORY_EN
   localparam int RW = $clog2(REFRAC_STEPS + 1);
   logic [RW-1:0] r_mem [NUM_NEURONS];

   lif_update_unit u_upd (
      .refrac (r_mem[idx] != '0),
      .u      (u_mem[idx]),
      .cur    (cur_data),
      .thr    (thr),
      .u_next (u_next),
      .spike  (spike)
   );

   // refractory counters: load on a spike, count down while waiting out the refractory period
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= '0;
      end else if (state == S_FETCH && cur_valid) begin
         r_mem[idx] <= spike ? RW'(REFRAC_STEPS) : (r_mem[idx] != '0 ? r_mem[idx] - RW'(1) : r_mem[idx]);
      end
   end
`else
   lif_update_unit u_upd (
      .u      (u_mem[idx]),
      .cur    (cur_data),
      .thr    (thr),
      .u_next (u_next),
      .spike  (spike)
   );
`endif

   // sequencer: walks idx over the array, owns membrane state, threshold and registered handshake outputs
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         thr       <= STATE_W'(THR_DEFAULT);
         spk_count <= '0;
         busy      <= 1'b0;
         step_done <= 1'b0;
         cur_req   <= 1'b0;
         spk_valid <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) u_mem[i] <= '0;
      end else begin
         step_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_we) thr <= cfg_thr;
               if (step_start) begin
                  state     <= S_FETCH;
                  idx       <= '0;
                  spk_count <= '0;
                  busy      <= 1'b1;
                  cur_req   <= 1'b1;
               end
            end
            S_FETCH: begin
               if (cur_valid) begin
                  u_mem[idx] <= u_next;
                  if (spike) begin
                     state     <= S_EMIT;
                     cur_req   <= 1'b0;
                     spk_valid <= 1'b1;
                  end else if (last) begin
                     state     <= S_DONE;
                     cur_req   <= 1'b0;
                     step_done <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (spk_ready) begin
                  spk_valid <= 1'b0;
                  spk_count <= spk_count == 8'hff ? spk_count : spk_count + 8'd1;
                  if (last) begin
                     state     <= S_DONE;
                     step_done <= 1'b1;
                  end else begin
                     state   <= S_FETCH;
                     idx     <= idx + 1'b1;
                     cur_req <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler: scoreboard bench with a timestep-level LIF reference model
module tb_lif_tdm_scheduler;
   localparam int N  = 8;
   localparam int IW = 3;
   localparam int REFRAC = 2;

   logic          clk = 1'b0, rst_n = 1'b1, step_start = 1'b0, cur_valid = 1'b0;
   logic          spk_ready = 1'b0, cfg_we = 1'b0;
   logic [7:0]    cur_data = '0, cfg_thr = '0;
   logic          busy, step_done, cur_req, spk_valid;
   logic [IW-1:0] cur_idx, spk_idx;
   logic [7:0]    spk_count;

   int errors = 0, checks = 0;
   int mu [N];
   int mr [N];
   int mthr;
   int cur_tab [N];
   int exp_spk [$];
   int exp_cnt [$];
   logic [8*N-1:0] exp_u [$];
   logic [8*N-1:0] mon_snap;

   bit rand_en = 0;
   bit stall_arm = 0;
   int stall_at = 0, stall_cnt = 0;
   bit hold_arm = 0;
   int hold_idx = 0, hold_len = 4, hold_cnt = 0;

   lif_tdm_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step_start (step_start),
      .busy       (busy),
      .step_done  (step_done),
      .cur_req    (cur_req),
      .cur_idx    (cur_idx),
      .cur_valid  (cur_valid),
      .cur_data   (cur_data),
      .spk_valid  (spk_valid),
      .spk_idx    (spk_idx),
      .spk_ready  (spk_ready),
      .cfg_we     (cfg_we),
      .cfg_thr    (cfg_thr),
      .spk_count  (spk_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mu[i] = 0;
         mr[i] = 0;
      end
      mthr = 230;
   endtask

   // one whole timestep of the reference neurons, pushing expected spikes and end state
   task automatic model_step();
      int c;
      logic [8*N-1:0] snap;
      int v;
      c = 0;
      for (int i = 0; i < N; i++) begin
`ifdef LIF_REFRACTORY_EN
         if (mr[i] > 0) begin
            mu[i] = 0;
            mr[i] = mr[i] - 1;
         end else
`endif
         if (mu[i] >= mthr) begin
            mu[i] = 0;
            mr[i] = REFRAC;
            exp_spk.push_back(i);
            c++;
         end else begin
            mu[i] = cur_tab[i] + mu[i] / 2 + mu[i] / 4 + mu[i] / 8;
            if (mu[i] > 255) mu[i] = 255;
         end
         v = mu[i];
         snap[8*i +: 8] = v[7:0];
      end
      exp_cnt.push_back(c > 255 ? 255 : c);
      exp_u.push_back(snap);
   endtask

   task automatic run_step(input int exp_lat, input bit cfg_mid);
      int n;
      bit done;
      model_step();
      @(negedge clk) step_start = 1'b1;
      n = 0;
      done = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         step_start = 1'b0;
         n++;
         cfg_we  = cfg_mid && n == 3;
         cfg_thr = 8'd20;
         if (step_done) done = 1;
      end
      cfg_we = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL step_timeout: got no step_done, expected one within 400 cycles");
      end
      if (exp_lat > 0) check("step_latency", n, exp_lat);
   endtask

   task automatic set_thr(input int v);
      @(negedge clk);
      cfg_we  = 1'b1;
      cfg_thr = 8'(v);
      @(negedge clk);
      cfg_we  = 1'b0;
      mthr    = v;
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < N; i++) cur_tab[i] = v;
   endtask

   // input-current source and spike consumer, with directed stalls and back-pressure
   always begin
      @(negedge clk);
      if (stall_cnt > 0) begin
         check("stall_cur_req", int'(cur_req), 1);
         check("stall_cur_idx", int'(cur_idx), stall_at);
         cur_valid = 1'b0;
         stall_cnt--;
      end else if (cur_req && stall_arm && int'(cur_idx) == stall_at) begin
         stall_arm = 0;
         stall_cnt = 2;
         cur_valid = 1'b0;
      end else if (cur_req) begin
         cur_valid = rand_en ? ($urandom_range(3) != 0) : 1'b1;
         cur_data  = 8'(cur_tab[cur_idx]);
      end else begin
         cur_valid = 1'($urandom_range(1));
         cur_data  = 8'($urandom_range(255));
      end
      if (hold_cnt > 0) begin
         check("hold_spk_valid", int'(spk_valid), 1);
         check("hold_spk_idx", int'(spk_idx), hold_idx);
         check("hold_no_fetch", int'(cur_req), 0);
         spk_ready = 1'b0;
         hold_cnt--;
      end else if (hold_arm && spk_valid) begin
         hold_arm = 0;
         check("hold_first_idx", int'(spk_idx), hold_idx);
         spk_ready = 1'b0;
         hold_cnt  = hold_len - 1;
      end else begin
         spk_ready = rand_en ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   // monitor: compares accepted spikes and end-of-step results against the scoreboard
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         if (spk_valid && spk_ready) begin
            if (exp_spk.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_spike: got spike on neuron %0d, expected none", spk_idx);
            end else begin
               check("spk_idx", int'(spk_idx), exp_spk.pop_front());
            end
         end
         if (step_done) begin
            if (exp_cnt.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got step_done, expected none");
            end else begin
               check("spk_count", int'(spk_count), exp_cnt.pop_front());
               mon_snap = exp_u.pop_front();
               for (int i = 0; i < N; i++)
                  check($sformatf("u[%0d]", i), int'(dut.u_mem[i]), int'(mon_snap[8*i +: 8]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_step_done"}, int'(step_done), 0);
      check({tag, "_cur_req"}, int'(cur_req), 0);
      check({tag, "_spk_valid"}, int'(spk_valid), 0);
      check({tag, "_spk_count"}, int'(spk_count), 0);
      check({tag, "_cur_idx"}, int'(cur_idx), 0);
   endtask

   initial begin
      bit seen;
      model_reset();
      fill(0);
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");

      fill(10);
      run_step(N + 1, 0);

      fill(0);
      cur_tab[3] = 192;
      run_step(0, 0);
      cur_tab[3] = 10;
      run_step(0, 0);
      cur_tab[3] = 39;
      run_step(0, 0);
      cur_tab[3] = 100;
      run_step(0, 0);
      check("u3_saturated", int'(dut.u_mem[3]), 255);

      fill(0);
      cur_tab[5] = 255;
      run_step(0, 0);
      fill(0);
      hold_idx = 5;
      hold_len = 4;
      hold_arm = 1;
      run_step(0, 0);
      check("hold_consumed", int'(hold_arm), 0);

      fill(30);
      stall_at  = 2;
      stall_arm = 1;
      run_step(0, 1);
      check("thr_after_busy_write", int'(dut.thr), 230);
      fill(0);
      run_step(0, 0);

      rand_en = 1;
      for (int s = 0; s < 20; s++) begin
         for (int i = 0; i < N; i++) cur_tab[i] = $urandom_range(255);
         if (s % 4 == 1) set_thr($urandom_range(255, 60));
         run_step(0, 0);
      end
      rand_en = 0;

      set_thr(255);
      fill(0);
      repeat (3) run_step(0, 0);
      set_thr(0);
      hold_idx = 0;
      hold_len = 1000;
      hold_arm = 1;
      @(negedge clk) step_start = 1'b1;
      @(negedge clk) step_start = 1'b0;
      seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (spk_valid) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL emit_wait: got no spk_valid, expected one within 100 cycles");
      end
      #2;
      hold_cnt = 0;
      hold_arm = 0;
      rst_n = 1'b1;
      #1;
      check_idle_outputs("mid_emit_reset");
      check("reset_thr", int'(dut.thr), 230);
      for (int i = 0; i < N; i++) check($sformatf("reset_u[%0d]", i), int'(dut.u_mem[i]), 0);
      exp_spk.delete();
      exp_cnt.delete();
      exp_u.delete();
      model_reset();
      @(negedge clk) rst_n = 1'b0;

      for (int i = 0; i < N; i++) cur_tab[i] = $urandom_range(200);
      run_step(N + 1, 0);

      fill(0);
      cur_tab[0] = 255;
      run_step(0, 0);
      fill(0);
      run_step(0, 0);
      fill(255);
      repeat (3) run_step(0, 0);

      repeat (3) @(negedge clk);
      check("spike_queue_drained", exp_spk.size(), 0);
      check("done_queue_drained", exp_cnt.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
